// File: rtl/cezar_stream_ctrl.sv
// rtl/cezar_stream_ctrl.sv - byte-stream sequencer around the codor_cezar encoder
//
// codor_cezar: combinational Caesar encoder over the 24-letter alphabet
//   a..t, w..z with shift +7 mod 24; any other byte maps to space (0x20).
//   char_i  in  8  input character
//   char_o  out 8  encoded character
//
// cezar_stream_ctrl: accepts bytes over valid/ready, runs each byte through
//   the encoder r_eff times via a registered feedback loop, then presents it.
//   clk            in   1      system clock, rising edge
//   rst            in   1      asynchronous active-high reset
//   rounds         in   5      encoder passes per byte (values >= 24 wrap)
//   in_data        in   8      input byte
//   in_last        in   1      last byte of a message
//   in_valid       in   1      input byte present
//   in_ready       out  1      controller can accept a byte
//   out_data       out  8      processed byte
//   out_last       out  1      in_last of this byte
//   out_valid      out  1      out_data/out_last valid
//   out_ready      in   1      sink accepts the byte
//   busy           out  1      byte is being encoded
//   char_cnt       out  CNT_W  bytes delivered (saturating)
//   nonletter_cnt  out  CNT_W  accepted non-alphabet bytes with r_eff != 0
// Build option: CEZAR_STATS_EN enables the two statistics counters; without
//   it both counter outputs are tied to zero.

module codor_cezar (
  input  logic [7:0] char_i,
  output logic [7:0] char_o
);
  logic [4:0] idx;
  logic [4:0] sh;
  logic       is_letter;

  always_comb begin
    idx       = 5'd0;
    is_letter = 1'b0;
    // Alphabet skips 'u' and 'v', so w..z map to indices 20..23.
    if (char_i >= 8'h61 && char_i <= 8'h74) begin
      idx       = 5'(char_i - 8'h61);
      is_letter = 1'b1;
    end else if (char_i >= 8'h77 && char_i <= 8'h7a) begin
      idx       = 5'(char_i - 8'h63);
      is_letter = 1'b1;
    end
    sh = (idx >= 5'd17) ? idx - 5'd17 : idx + 5'd7;
    if (!is_letter) begin
      char_o = 8'h20;
    end else if (sh < 5'd20) begin
      char_o = 8'h61 + {3'b000, sh};
    end else begin
      char_o = 8'h63 + {3'b000, sh};
    end
  end
endmodule

module cezar_stream_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rounds,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] nonletter_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_OUT} state_t;

  state_t     state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [4:0] rc_q, rc_d;
  logic       last_q, last_d;
  logic [7:0] enc_out;
  logic [4:0] r_eff;

  codor_cezar u_enc (
    .char_i (d_q),
    .char_o (enc_out)
  );

  // 24 rounds is the identity, so larger requests fold back into 0..7.
  assign r_eff = (rounds >= 5'd24) ? rounds - 5'd24 : rounds;

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    rc_d      = rc_q;
    last_d    = last_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Reset forces IDLE asynchronously; keep in_ready low until release.
        in_ready = ~rst;
        if (in_valid) begin
          d_d     = in_data;
          rc_d    = r_eff;
          last_d  = in_last;
          state_d = (r_eff == 5'd0) ? S_OUT : S_ROUND;
        end
      end
      S_ROUND: begin
        busy = 1'b1;
        d_d  = enc_out;
        rc_d = rc_q - 5'd1;
        if (rc_q == 5'd1) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            d_d     = in_data;
            rc_d    = r_eff;
            last_d  = in_last;
            state_d = (r_eff == 5'd0) ? S_OUT : S_ROUND;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= 8'h00;
      rc_q    <= 5'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      rc_q    <= rc_d;
      last_q  <= last_d;
    end
  end

  assign out_data = d_q;
  assign out_last = last_q;

`ifdef CEZAR_STATS_EN
  logic [CNT_W-1:0] char_cnt_q;
  logic [CNT_W-1:0] nl_cnt_q;
  logic             in_alpha;
  logic             accept;
  logic             xfer;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign in_alpha = (in_data >= 8'h61 && in_data <= 8'h74) ||
                    (in_data >= 8'h77 && in_data <= 8'h7a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_cnt_q <= '0;
      nl_cnt_q   <= '0;
    end else begin
      if (xfer && char_cnt_q != '1) begin
        char_cnt_q <= char_cnt_q + ONE;
      end
      if (accept && !in_alpha && r_eff != 5'd0 && nl_cnt_q != '1) begin
        nl_cnt_q <= nl_cnt_q + ONE;
      end
    end
  end

  assign char_cnt      = char_cnt_q;
  assign nonletter_cnt = nl_cnt_q;
`else
  assign char_cnt      = '0;
  assign nonletter_cnt = '0;
`endif
endmodule

// File: tb/tb_cezar_stream_ctrl.sv
// tb/tb_cezar_stream_ctrl.sv - directed scoreboard bench for cezar_stream_ctrl
module tb_cezar_stream_ctrl;
  logic        clk;
  logic        rst;
  logic [4:0]  rounds;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] char_cnt;
  logic [15:0] nonletter_cnt;

`ifdef CEZAR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  int         char_exp = 0;
  int         nl_exp = 0;
  logic [8:0] sb[$];

  cezar_stream_ctrl #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rounds        (rounds),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .char_cnt      (char_cnt),
    .nonletter_cnt (nonletter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  function automatic bit is_alpha(input logic [7:0] c);
    string al = "abcdefghijklmnopqrstwxyz";
    for (int i = 0; i < 24; i++) if (al[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] enc1(input logic [7:0] c);
    string al = "abcdefghijklmnopqrstwxyz";
    for (int i = 0; i < 24; i++) if (al[i] == c) return al[(i + 7) % 24];
    return 8'h20;
  endfunction

  function automatic int reff(input logic [4:0] r);
    return (r >= 24) ? int'(r) - 24 : int'(r);
  endfunction

  function automatic logic [7:0] model(input logic [7:0] b, input logic [4:0] r);
    logic [7:0] x = b;
    for (int i = 0; i < reff(r); i++) x = enc1(x);
    return x;
  endfunction

  // Drive one byte from IDLE; returns #1 after the acceptance edge.
  task automatic send(input logic [7:0] b, input logic lst, input logic [4:0] r);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    rounds   = r;
    in_data  = b;
    in_last  = lst;
    in_valid = 1'b1;
    sb.push_back({lst, model(b, r)});
    if (reff(r) != 0 && !is_alpha(b)) nl_exp++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rounds   = 5'd31;
  endtask

  // Called #1 after the acceptance edge; ends on the negedge where out_valid rises.
  task automatic wait_out(input int exp_lat);
    int lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      chk("busy_round", busy, 1);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic pop_cmp();
    logic [8:0] e = 9'h0;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    chk("out_data", out_data, e[7:0]);
    chk("out_last", out_last, e[8]);
  endtask

  task automatic recv();
    pop_cmp();
    out_ready = 1'b1;
    #1;
    chk("in_ready_out", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    char_exp++;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("char_cnt", char_cnt, stat(char_exp));
    chk("nonletter_cnt", nonletter_cnt, stat(nl_exp));
  endtask

  initial begin
    rst = 1'b1; rounds = 5'd0; in_data = 8'h0; in_last = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 0);
    chk("rst_char_cnt", char_cnt, 0);
    chk("rst_nl_cnt", nonletter_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Encrypt
    send(8'h61, 1'b1, 5'd1); wait_out(1); recv();
    send(8'h7a, 1'b0, 5'd1); wait_out(1); recv();
    send(8'h6e, 1'b0, 5'd1); wait_out(1); recv();
    // Decrypt and wrap
    send(8'h68, 1'b0, 5'd23); wait_out(23); recv();
    send(8'h61, 1'b1, 5'd25); wait_out(1); recv();
    // Non-letters
    send(8'h75, 1'b0, 5'd1); wait_out(1); recv();
    send(8'h41, 1'b1, 5'd1); wait_out(1); recv();
    chk("nl_two", nonletter_cnt, stat(2));
    send(8'h41, 1'b0, 5'd0); wait_out(0); recv();

    // Backpressure then back-to-back transfer + accept on one edge
    send(8'h62, 1'b0, 5'd1); wait_out(1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 8'h69);
      @(negedge clk);
    end
    pop_cmp();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h63; in_last = 1'b1; rounds = 5'd1;
    sb.push_back({1'b1, model(8'h63, 5'd1)});
    #1;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; rounds = 5'd31;
    char_exp++;
    wait_out(1);
    chk("b2b_char_cnt", char_cnt, stat(char_exp));
    recv();

    // Reset while a byte waits in OUT
    send(8'h78, 1'b1, 5'd0); wait_out(0);
    #2 rst = 1'b1;
    #1;
    chk("rout_out_valid", out_valid, 0);
    chk("rout_out_data", out_data, 8'h00);
    chk("rout_out_last", out_last, 0);
    chk("rout_in_ready", in_ready, 0);
    chk("rout_char_cnt", char_cnt, 0);
    void'(sb.pop_back());
    char_exp = 0; nl_exp = 0;
    @(negedge clk);
    #2 rst = 1'b0;

    // Reset mid-ROUND
    send(8'h61, 1'b0, 5'd10);
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rrnd_busy", busy, 0);
    chk("rrnd_out_valid", out_valid, 0);
    chk("rrnd_in_ready", in_ready, 0);
    chk("rrnd_out_data", out_data, 8'h00);
    chk("rrnd_char_cnt", char_cnt, 0);
    chk("rrnd_nl_cnt", nonletter_cnt, 0);
    void'(sb.pop_back());
    char_exp = 0; nl_exp = 0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rrnd_no_xfer", out_valid, 0);
    end
    out_ready = 1'b0;
    #2 rst = 1'b0;
    send(8'h6e, 1'b1, 5'd1); wait_out(1); recv();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cezar_stream_ctrl.md
# cezar_stream_ctrl

Sequencing controller for the combinational Caesar encoder `codor_cezar` (24-letter lowercase alphabet a–t, w–z; shift +7 mod 24; any other byte maps to space 0x20). It accepts a byte stream over a valid/ready handshake and applies the encoder a programmable number of rounds per byte through a registered feedback loop. One round encrypts and 23 rounds decrypt, because 7·23 ≡ −7 (mod 24). The block sits between the UART/byte source and the display/transmit sink of the lab cipher path.

## Interface
- CNT_W, 16, width of the statistics counters
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rounds  in  5  encoder passes per byte; sampled at input acceptance
- in_data  in  8  input byte
- in_last  in  1  marks the last byte of a message
- in_valid  in  1  input byte present
- in_ready  out  1  controller can accept a byte
- out_data  out  8  processed byte
- out_last  out  1  copy of in_last for this byte
- out_valid  out  1  out_data/out_last valid
- out_ready  in  1  sink accepts the byte
- busy  out  1  a byte is being processed (ROUND state)
- char_cnt  out  CNT_W  bytes delivered on the output (stats)
- nonletter_cnt  out  CNT_W  accepted bytes outside the alphabet with effective rounds ≠ 0 (stats)

## Operation
- Internal datapath: data register `d`, round counter `rc[4:0]`, last flag. One `codor_cezar` instance is fed from `d`.
- Effective rounds: `r_eff = rounds` if `rounds < 24`, otherwise `rounds − 24`.
- The FSM has three states: IDLE, ROUND and OUT.
  - IDLE: `in_ready = 1`. When `in_valid` is high at the edge, `d ← in_data`, `rc ← r_eff`, `last ← in_last`. Next state is OUT if `r_eff = 0`, otherwise ROUND.
  - ROUND: `busy = 1`, `in_ready = 0`. Each edge performs `d ← enc(d)` and `rc ← rc − 1`. When `rc = 1` at the edge, next state is OUT.
  - OUT: `out_valid = 1`, `out_data = d`, `out_last = last`, `in_ready = out_ready`.
    - Transfer with `in_valid = 0`: go to IDLE.
    - Transfer with `in_valid = 1`: the new byte is loaded exactly as in IDLE (back-to-back).
    - No transfer: `d`, `out_data` and `out_last` are held stable.
- A non-letter becomes 0x20 after the first round. Space stays space on later rounds. With `r_eff = 0` every byte passes unchanged, including uppercase.
- `rounds` changing while a byte is in ROUND has no effect on that byte.
- char_cnt increments on each output transfer (`out_valid & out_ready`).
- nonletter_cnt increments on acceptance of a non-alphabet byte when `r_eff ≠ 0`.
- Both counters saturate at 2^CNT_W − 1.

## Timing
- Reset values:
  - state IDLE, `d = 0x00`, `rc = 0`
  - `out_data = 0x00`, `out_last = 0`, `out_valid = 0`, `busy = 0`
  - `char_cnt = 0`, `nonletter_cnt = 0`
  - `in_ready = 0` while `rst` is high, `1` in the first cycle after release
- Latency: for a byte accepted at edge E, `out_valid` is high after edge E + r_eff (r_eff = 0: visible right after E).
- Throughput: one byte per `r_eff + 1` cycles with `out_ready` held high.
- `in_ready` and `out_valid` are never both high from IDLE. `in_ready` in OUT is combinational from `out_ready`.
- Reset asserted mid-ROUND or mid-OUT: the byte in flight is discarded, all outputs return to reset values immediately (asynchronous), and no transfer completes.

## Configuration
- `CEZAR_STATS_EN` defined: `char_cnt` and `nonletter_cnt` are implemented as above.
- `CEZAR_STATS_EN` undefined: no counter flops are built, and both outputs are tied to 0.
- The datapath and handshake are identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs at reset values at once; `in_ready = 1` one cycle after release.
- Encrypt: `rounds = 1`, 'a' (0x61) with `in_last = 1` -> `out_data = 'h'` (0x68), `out_last = 1`, `out_valid` after edge E+1.
  - Follow with 'z' -> 'g'; 'n' -> 'w'.
- Decrypt and wrap: `rounds = 23`, 'h' -> 'a' after 23 round cycles.
  - `rounds = 25` on 'a' -> 'h' (r_eff = 1).
- Non-letters: `rounds = 1` on 'u', then 'A' -> 0x20, 0x20; `nonletter_cnt = 2`.
  - `rounds = 0` on 'A' -> 'A' at latency 0; `nonletter_cnt` unchanged.
- Backpressure and back-to-back: `rounds = 1` with `out_ready = 0` for 5 cycles -> `out_data` held.
  - Then `out_ready = 1` with `in_valid = 1` -> transfer and new accept on the same edge; `char_cnt` increments per transfer.
- Reset mid-ROUND: `rounds = 10`, assert `rst` at round 4 -> no output transfer; `char_cnt = 0`.
  - Next byte after release processes normally.
